// File: rtl/lifo_seq_pkg.sv
// Shared encodings for the LIFO command sequencer: primitive stack effects, opcodes, error codes.
// The depth-checking feature is enabled by defining LIFO_SEQ_DEPTH_CHK_EN.
package lifo_seq_pkg;

  typedef enum logic [2:0] {
    NONE_SE = 3'd0,
    DROP_SE = 3'd1,
    PUSH_SE = 3'd2,
    RPLC_SE = 3'd3,
    SWAP_SE = 3'd4,
    OVER_SE = 3'd5,
    ROT3_SE = 3'd6
  } se_e;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_DROP  = 4'd2;
  localparam logic [3:0] OP_DUP   = 4'd3;
  localparam logic [3:0] OP_SWAP  = 4'd4;
  localparam logic [3:0] OP_OVER  = 4'd5;
  localparam logic [3:0] OP_ROT   = 4'd6;
  localparam logic [3:0] OP_NIP   = 4'd7;
  localparam logic [3:0] OP_TUCK  = 4'd8;
  localparam logic [3:0] OP_DROP2 = 4'd9;
  localparam logic [3:0] OP_DUP2  = 4'd10;
  localparam logic [3:0] OP_MROT  = 4'd11;
  localparam logic [3:0] OP_RPLC  = 4'd12;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    DSEL_ZERO,
    DSEL_IN,
    DSEL_S0
  } dsel_e;

  typedef struct packed {
    se_e   se1;
    se_e   se2;
    logic  two_step;
    dsel_e data_sel;
    logic  illegal;
  } dec_t;

endpackage

// File: rtl/lifo_seq_dec.sv
// Combinational decode of a compound stack op into one or two primitive stack effects.
// min_depth/growth ports exist only when LIFO_SEQ_DEPTH_CHK_EN is defined.
module lifo_seq_dec
  import lifo_seq_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
`ifdef LIFO_SEQ_DEPTH_CHK_EN
  ,
  output logic [1:0] min_depth,
  output logic [2:0] growth
`endif
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    dec = '{se1: NONE_SE, se2: NONE_SE, two_step: 1'b0, data_sel: DSEL_ZERO, illegal: 1'b0};
    case (op)
      OP_NOP:   ;
      OP_PUSH:  begin dec.se1 = PUSH_SE; dec.data_sel = DSEL_IN; end
      OP_DROP:  dec.se1 = DROP_SE;
      OP_DUP:   begin dec.se1 = PUSH_SE; dec.data_sel = DSEL_S0; end
      OP_SWAP:  dec.se1 = SWAP_SE;
      OP_OVER:  dec.se1 = OVER_SE;
      OP_ROT:   dec.se1 = ROT3_SE;
      OP_NIP:   begin dec.se1 = SWAP_SE; dec.se2 = DROP_SE; dec.two_step = 1'b1; end
      OP_TUCK:  begin dec.se1 = SWAP_SE; dec.se2 = OVER_SE; dec.two_step = 1'b1; end
      OP_DROP2: begin dec.se1 = DROP_SE; dec.se2 = DROP_SE; dec.two_step = 1'b1; end
      OP_DUP2:  begin dec.se1 = OVER_SE; dec.se2 = OVER_SE; dec.two_step = 1'b1; end
      OP_MROT:  begin dec.se1 = ROT3_SE; dec.se2 = ROT3_SE; dec.two_step = 1'b1; end
      OP_RPLC:  begin dec.se1 = RPLC_SE; dec.data_sel = DSEL_IN; end
      default:  dec.illegal = 1'b1;
    endcase
  end

`ifdef LIFO_SEQ_DEPTH_CHK_EN
  // growth is two's complement: 3'b111 = -1, 3'b110 = -2
  always_comb begin
    min_depth = 2'd0;
    growth    = 3'd0;
    case (op)
      OP_PUSH:  growth = 3'd1;
      OP_DROP:  begin min_depth = 2'd1; growth = 3'b111; end
      OP_DUP:   begin min_depth = 2'd1; growth = 3'd1;   end
      OP_SWAP:  min_depth = 2'd2;
      OP_OVER:  begin min_depth = 2'd2; growth = 3'd1;   end
      OP_ROT:   min_depth = 2'd3;
      OP_NIP:   begin min_depth = 2'd2; growth = 3'b111; end
      OP_TUCK:  begin min_depth = 2'd2; growth = 3'd1;   end
      OP_DROP2: begin min_depth = 2'd2; growth = 3'b110; end
      OP_DUP2:  begin min_depth = 2'd2; growth = 3'd2;   end
      OP_MROT:  min_depth = 2'd3;
      OP_RPLC:  min_depth = 2'd1;
      default:  ;
    endcase
  end
`endif

endmodule

// File: rtl/lifo_seq.sv
// Command-side sequencer for the stack-effect LIFO: accepts compound ops, issues primitive effects.
// Define LIFO_SEQ_DEPTH_CHK_EN to build the depth counter and underflow/overflow checks.
module lifo_seq
  import lifo_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 12,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_s0,
  output logic [2:0]       o_se,
  output logic [WIDTH-1:0] o_data,
  output logic [DW-1:0]    o_depth,
  output logic             o_err,
  output logic [1:0]       o_err_code
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE1 = 2'd1;
  localparam logic [1:0] ISSUE2 = 2'd2;

  logic [1:0]       state;
  se_e              se_q;
  se_e              se2_q;
  logic [WIDTH-1:0] data_q;
  logic             err;
  logic [1:0]       err_code;

  dec_t             dec;
  logic             accept;
  logic             underflow;
  logic             overflow;
  logic             fault;
  logic             issue;
  logic [1:0]       fault_code;
  logic [WIDTH-1:0] data_in;

`ifdef LIFO_SEQ_DEPTH_CHK_EN
  logic [1:0]          min_depth;
  logic [2:0]          growth;
  logic [DW-1:0]       depth_q;
  logic signed [DW+1:0] depth_sum;

  lifo_seq_dec u_dec (
    .op        (i_op),
    .dec       (dec),
    .min_depth (min_depth),
    .growth    (growth)
  );

  // Two guard bits keep the signed sum exact, so the checks never see a wrapped value.
  assign depth_sum = $signed({2'b00, depth_q}) + $signed({{(DW-1){growth[2]}}, growth});
  assign underflow = depth_q < DW'(min_depth);
  assign overflow  = depth_sum > $signed((DW+2)'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst)      depth_q <= '0;
    else if (issue) depth_q <= depth_sum[DW-1:0];
  end

  assign o_depth = depth_q;
`else
  lifo_seq_dec u_dec (
    .op  (i_op),
    .dec (dec)
  );

  assign underflow = 1'b0;
  assign overflow  = 1'b0;
  assign o_depth   = '0;
`endif

  assign o_ready    = (state == IDLE) && !i_rst;
  assign accept     = i_valid && o_ready;
  assign fault      = accept && !err && (dec.illegal || underflow || overflow);
  assign issue      = accept && !err && !dec.illegal && !underflow && !overflow && (dec.se1 != NONE_SE);
  assign fault_code = dec.illegal ? ERR_ILLEGAL : (underflow ? ERR_UNDER : ERR_OVER);

  always_comb begin
    case (dec.data_sel)
      DSEL_IN: data_in = i_data;
      DSEL_S0: data_in = i_s0;
      default: data_in = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      se_q     <= NONE_SE;
      se2_q    <= NONE_SE;
      data_q   <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state  <= ISSUE1;
            se_q   <= dec.se1;
            se2_q  <= dec.two_step ? dec.se2 : NONE_SE;
            data_q <= data_in;
          end
        end
        ISSUE1: begin
          data_q <= '0;
          se2_q  <= NONE_SE;
          if (se2_q != NONE_SE) begin
            state <= ISSUE2;
            se_q  <= se2_q;
          end else begin
            state <= IDLE;
            se_q  <= NONE_SE;
          end
        end
        default: begin
          state  <= IDLE;
          se_q   <= NONE_SE;
          data_q <= '0;
        end
      endcase
      // Only the first fault is recorded; later ops are swallowed while err stays set.
      if (fault) begin
        err      <= 1'b1;
        err_code <= fault_code;
      end
    end
  end

  assign o_se       = se_q;
  assign o_data     = data_q;
  assign o_err      = err;
  assign o_err_code = err_code;

endmodule

// File: tb/tb_lifo_seq.sv
// Self-checking bench for lifo_seq: a queue-based LIFO stand-in closes the i_s0 loop, and a
// Forth-level reference stack predicts issued effects, data, depth and errors.
module tb_lifo_seq;
  import lifo_seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [3:0]       i_op = 4'd0;
  logic [WIDTH-1:0] i_data = '0;
  logic [WIDTH-1:0] i_s0 = '0;
  logic [2:0]       o_se;
  logic [WIDTH-1:0] o_data;
  logic [DW-1:0]    o_depth;
  logic             o_err;
  logic [1:0]       o_err_code;

  lifo_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_data     (i_data),
    .i_s0       (i_s0),
    .o_se       (o_se),
    .o_data     (o_data),
    .o_depth    (o_depth),
    .o_err      (o_err),
    .o_err_code (o_err_code)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] lifo[$];
  int               ref_stk[$];
  bit               ref_err;
  logic [1:0]       ref_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Primitive LIFO stand-in, driven by whatever the DUT issues.
  always @(posedge i_clk) begin
    logic [WIDTH-1:0] t;
    if (i_rst) lifo.delete();
    else begin
      case (o_se)
        PUSH_SE: lifo.push_front(o_data);
        DROP_SE: if (lifo.size() > 0) void'(lifo.pop_front());
        SWAP_SE: if (lifo.size() > 1) begin t = lifo[0]; lifo[0] = lifo[1]; lifo[1] = t; end
        OVER_SE: if (lifo.size() > 1) lifo.push_front(lifo[1]);
        ROT3_SE: if (lifo.size() > 2) begin t = lifo[2]; lifo.delete(2); lifo.push_front(t); end
        RPLC_SE: if (lifo.size() > 0) lifo[0] = o_data;
        default: ;
      endcase
    end
  end

  always @(negedge i_clk) i_s0 = (lifo.size() > 0) ? lifo[0] : '0;

  function automatic int min_of(input logic [3:0] op);
    case (op)
      OP_DROP, OP_DUP, OP_RPLC:                            return 1;
      OP_SWAP, OP_OVER, OP_NIP, OP_TUCK, OP_DROP2, OP_DUP2: return 2;
      OP_ROT, OP_MROT:                                     return 3;
      default:                                             return 0;
    endcase
  endfunction

  function automatic int grow_of(input logic [3:0] op);
    case (op)
      OP_PUSH, OP_DUP, OP_OVER, OP_TUCK: return 1;
      OP_DROP, OP_NIP:                   return -1;
      OP_DROP2:                          return -2;
      OP_DUP2:                           return 2;
      default:                           return 0;
    endcase
  endfunction

  function automatic void seq_of(input logic [3:0] op, output logic [2:0] s1, output logic [2:0] s2);
    s2 = NONE_SE;
    case (op)
      OP_PUSH, OP_DUP: s1 = PUSH_SE;
      OP_DROP:  s1 = DROP_SE;
      OP_SWAP:  s1 = SWAP_SE;
      OP_OVER:  s1 = OVER_SE;
      OP_ROT:   s1 = ROT3_SE;
      OP_NIP:   begin s1 = SWAP_SE; s2 = DROP_SE; end
      OP_TUCK:  begin s1 = SWAP_SE; s2 = OVER_SE; end
      OP_DROP2: begin s1 = DROP_SE; s2 = DROP_SE; end
      OP_DUP2:  begin s1 = OVER_SE; s2 = OVER_SE; end
      OP_MROT:  begin s1 = ROT3_SE; s2 = ROT3_SE; end
      OP_RPLC:  s1 = RPLC_SE;
      default:  s1 = NONE_SE;
    endcase
  endfunction

  // Forth semantics on the reference stack (index 0 is top of stack).
  task automatic apply_ref(input logic [3:0] op, input logic [WIDTH-1:0] d);
    int a, b;
    case (op)
      OP_PUSH:  ref_stk.push_front(int'(d));
      OP_DROP:  if (ref_stk.size() > 0) void'(ref_stk.pop_front());
      OP_DUP:   ref_stk.push_front(ref_stk[0]);
      OP_SWAP:  begin a = ref_stk[0]; ref_stk[0] = ref_stk[1]; ref_stk[1] = a; end
      OP_OVER:  ref_stk.push_front(ref_stk[1]);
      OP_ROT:   begin a = ref_stk[2]; ref_stk.delete(2); ref_stk.push_front(a); end
      OP_NIP:   ref_stk.delete(1);
      OP_TUCK:  ref_stk.insert(2, ref_stk[0]);
      OP_DROP2: begin void'(ref_stk.pop_front()); void'(ref_stk.pop_front()); end
      OP_DUP2:  begin a = ref_stk[0]; b = ref_stk[1]; ref_stk.push_front(b); ref_stk.push_front(a); end
      OP_MROT:  begin a = ref_stk.pop_front(); ref_stk.insert(2, a); end
      OP_RPLC:  ref_stk[0] = int'(d);
      default:  ;
    endcase
  endtask

  function automatic int exp_depth();
`ifdef LIFO_SEQ_DEPTH_CHK_EN
    return ref_stk.size();
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_valid = 1'b0;
    @(negedge i_clk);
    check("rst_ready", o_ready, 0);
    check("rst_se", o_se, NONE_SE);
    check("rst_data", o_data, 0);
    check("rst_depth", o_depth, 0);
    check("rst_err", o_err, 0);
    check("rst_code", o_err_code, ERR_NONE);
    i_rst = 1'b0;
    ref_stk.delete();
    ref_err  = 1'b0;
    ref_code = ERR_NONE;
    @(negedge i_clk);
    check("rst_ready_after", o_ready, 1);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [WIDTH-1:0] d);
    logic [2:0]       s1, s2;
    logic [WIDTH-1:0] d1;
    logic [1:0]       code;
    int               nsteps, w;
    w = 0;
    while (!o_ready && w < 8) begin @(negedge i_clk); w++; end
    check("accept_ready", o_ready, 1);
    nsteps = 0;
    d1     = '0;
    code   = ERR_NONE;
    s1     = NONE_SE;
    s2     = NONE_SE;
    if (!ref_err) begin
      if (op >= 4'd13) code = ERR_ILLEGAL;
`ifdef LIFO_SEQ_DEPTH_CHK_EN
      else if (ref_stk.size() < min_of(op)) code = ERR_UNDER;
      else if (ref_stk.size() + grow_of(op) > DEPTH) code = ERR_OVER;
`endif
      if (code != ERR_NONE) begin
        ref_err  = 1'b1;
        ref_code = code;
      end else if (op != OP_NOP) begin
        seq_of(op, s1, s2);
        nsteps = (s2 == NONE_SE) ? 1 : 2;
        if (op == OP_PUSH || op == OP_RPLC) d1 = d;
        else if (op == OP_DUP) d1 = (ref_stk.size() > 0) ? WIDTH'(ref_stk[0]) : '0;
        apply_ref(op, d);
      end
    end
    i_valid = 1'b1;
    i_op    = op;
    i_data  = d;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data  = WIDTH'($urandom);
    check("depth_n1", o_depth, exp_depth());
    for (int k = 0; k < nsteps; k++) begin
      check("issue_se", o_se, (k == 0) ? s1 : s2);
      check("issue_data", o_data, (k == 0) ? d1 : '0);
      check("busy_ready", o_ready, 0);
      @(negedge i_clk);
    end
    check("idle_se", o_se, NONE_SE);
    check("idle_data", o_data, 0);
    check("idle_ready", o_ready, 1);
    check("err", o_err, ref_err);
    check("err_code", o_err_code, ref_code);
    check("depth", o_depth, exp_depth());
    check("stack_size", lifo.size(), ref_stk.size());
    for (int i = 0; i < ref_stk.size() && i < lifo.size(); i++)
      check("stack_elem", lifo[i], ref_stk[i]);
  endtask

  initial begin
    logic [3:0] op;
    int         sz;

    // Reset, then PUSH 5, PUSH 7, TUCK -> stack 7,5,7
    do_reset();
    do_op(OP_PUSH, 8'd5);
    do_op(OP_PUSH, 8'd7);
    do_op(OP_TUCK, 8'hAA);
    check("tuck_s0", lifo[0], 7);
    check("tuck_s1", lifo[1], 5);
    check("tuck_s2", lifo[2], 7);

    // PUSH 1,2,3 then MROT -> s0=2 s1=1 s2=3
    do_reset();
    do_op(OP_PUSH, 8'd1);
    do_op(OP_PUSH, 8'd2);
    do_op(OP_PUSH, 8'd3);
    do_op(OP_MROT, 8'h55);
    check("mrot_s0", lifo[0], 2);
    check("mrot_s1", lifo[1], 1);
    check("mrot_s2", lifo[2], 3);

    // DUP takes its literal from the fed-back top of stack
    do_reset();
    do_op(OP_PUSH, 8'h3C);
    do_op(OP_DUP, 8'h00);
    check("dup_s1", lifo[1], 8'h3C);

    // Illegal opcode is sticky and swallows the next op
    do_op(4'd14, 8'h11);
    check("illegal_code", o_err_code, 2'b11);
    do_op(OP_PUSH, 8'h22);

    // Reset while NIP is in its first step: the DROP must never appear
    do_reset();
    do_op(OP_PUSH, 8'd1);
    do_op(OP_PUSH, 8'd2);
    i_valid = 1'b1;
    i_op    = OP_NIP;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("nip_step1", o_se, SWAP_SE);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("nip_abandon_se", o_se, NONE_SE);
    check("nip_abandon_depth", o_depth, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("nip_after_se", o_se, NONE_SE);
    check("nip_after_ready", o_ready, 1);

`ifdef LIFO_SEQ_DEPTH_CHK_EN
    do_reset();
    do_op(OP_DROP, 8'h00);
    check("under_code", o_err_code, 2'b01);
    do_op(OP_PUSH, 8'd9);
    check("under_discard_depth", o_depth, 0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) do_op(OP_PUSH, WIDTH'(i + 1));
    check("full_depth", o_depth, DEPTH);
    do_op(OP_DUP2, 8'h00);
    check("full_dup2_code", o_err_code, 2'b10);
    check("full_dup2_depth", o_depth, DEPTH);

    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) do_op(OP_PUSH, WIDTH'(i + 1));
    do_op(OP_DUP2, 8'h00);
    check("nearfull_dup2_code", o_err_code, 2'b10);

    do_reset();
    do_op(OP_PUSH, 8'd4);
    do_op(OP_DROP2, 8'h00);
    check("drop2_under_code", o_err_code, 2'b01);
`else
    do_reset();
    do_op(OP_DROP, 8'h00);
    check("nochk_err", o_err, 0);
    check("nochk_depth", o_depth, 0);
`endif

    // Randomized legal traffic, each round ending with a fault and a discarded op
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int n = 0; n < 40; n++) begin
        sz = ref_stk.size();
        op = 4'($urandom_range(0, 12));
        while (sz < min_of(op) || sz + grow_of(op) > DEPTH) op = 4'($urandom_range(0, 12));
        do_op(op, WIDTH'($urandom));
      end
      do_op(4'($urandom_range(13, 15)), WIDTH'($urandom));
      do_op(OP_PUSH, WIDTH'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
